service_arbiter: RTL
====================

Name: service_arbiter

Overview:
- Time-shares the 7-segment display bus and the 5 push buttons among the four services (time set, alarm set, minigame, alarm check).
- The service-select switches request ownership. Alarm ringing pre-empts to service 4.
- Switchover inserts a blanking gap, and buttons are re-armed only after release, so presses never leak between services.
- Sits between the Main switch/button decode and the per-service modules; it drives the number bus that feeds the 7-segment encoder.

Parameters:
- BLANK_CYCLES, 4, display-blank cycles on every ownership change; must be >= 1.
- N_SVC, 4, number of services; fixed, not meant to be overridden.

Ports:
- clk  in  1  system clock; every flop is posedge clk.
- resetn  in  1  synchronous, active-high reset (name kept from the codebase; 1 = reset).
- svc_sel  in  4  service switches; bit3 = service1 ... bit0 = service4.
- push  in  5  raw buttons {m,r,l,d,u} (bit4 = middle).
- svc_num  in  64  per-service digit buses; [63:48] = service1 ... [15:0] = service4; 4 BCD digits each.
- svc_an  in  16  per-service digit enables; [15:12] = service1.
- svc_finish  in  4  per-service done pulses, same bit order as svc_sel.
- alarm_ring  in  1  current time equals alarm time (level).
- grant  out  4  one-hot current owner; 0 = none.
- svc_push  out  20  gated buttons; [19:15] = service1.
- disp_num  out  16  digits to the 7-segment encoder.
- disp_an  out  4  digit enables.
- sel_err  out  1  more than one svc_sel bit set while IDLE.

Behaviour:
- All outputs are registered.
- Reset (resetn = 1 at a clock edge) takes effect the next cycle, including mid-operation:
  - state = IDLE, grant = 0, svc_push = 0, disp_an = 0, sel_err = 0;
  - disp_num = 16'hFFFF (all digits blank).
- States: IDLE = 0, BLANK = 1, OWN = 2, LOCK = 3. Internal registers: target[3:0], cnt, alarm_pre (alarm pre-emption flag), armed.
- IDLE:
  - svc_sel exactly one-hot: target = svc_sel, cnt = BLANK_CYCLES-1, go to BLANK; sel_err = 0.
  - svc_sel == 0: stay; sel_err = 0.
  - svc_sel multi-hot: stay; sel_err = 1 until the selection becomes legal.
- BLANK:
  - grant = 0, disp_num = FFFF, disp_an = 0, svc_push = 0.
  - cnt decrements each cycle; on the cycle cnt == 0, go to OWN, grant = target, armed = 0.
  - First grant is therefore visible BLANK_CYCLES+1 cycles after the sel edge that IDLE samples.
- OWN:
  - disp_num/disp_an = owner's slice of svc_num/svc_an, one cycle of latency.
  - armed sets on the first cycle push == 0. While armed, the owner's svc_push slice = push, registered (one-cycle latency). All other slices = 0.
  - Exit to IDLE (grant = 0 next cycle) when svc_sel[owner] drops, unless alarm_pre is set.
  - Other svc_sel bits rising while the owner bit is held are ignored (first come wins).
  - svc_finish[owner] = 1 with alarm_pre = 0: go to LOCK.
- LOCK:
  - grant = 0, display blank, pushes gated.
  - Return to IDLE only once svc_sel[owner] == 0, so a finished service is not re-granted immediately.
- Alarm pre-emption:
  - Trigger: alarm_ring = 1 in IDLE, OWN or LOCK while grant != 4'b0001.
  - Action: target = 4'b0001, alarm_pre = 1, go to BLANK. This wins over any same-cycle svc_sel change or svc_finish.
  - While alarm_pre is set, switches are ignored.
  - svc_finish[0] clears alarm_pre and goes to IDLE, not LOCK.
  - alarm_ring held high after that finish does not re-trigger. Re-arm requires alarm_ring to go low for at least 1 cycle (edge-qualified).
- svc_finish bits for non-owners are ignored in every state.
- svc_push is never nonzero outside OWN.

Decomposition:
- Shared package holds:
  - state encodings;
  - service one-hot constants SVC1..SVC4 = 8,4,2,1;
  - BLANK_DIGITS = 16'hFFFF;
  - push bit indices U = 0, D = 1, L = 2, R = 3, M = 4.
- One sub-module, service_push_gate: owns armed, release-wait and the one-cycle push register, and produces the 20-bit gated output from grant.
- The 4:1 display mux stays inline.

Test Plan:
- Basic grant: reset, then svc_sel = 4'b1000 with svc_num[63:48] = 16'h1234.
  - grant = 4'b1000 exactly 5 cycles after the sel edge that IDLE samples (BLANK_CYCLES = 4).
  - disp_num = 16'h1234 one cycle later.
  - disp_num = FFFF throughout BLANK.
- Button carry-over: hold push = 5'b00001 across the grant.
  - svc_push stays 0 until push returns to 0.
  - A later press of u appears at svc_push[15] only, one cycle delayed.
- Illegal and contended select:
  - svc_sel = 4'b1100 in IDLE: sel_err = 1, grant stays 0.
  - Owner 4'b0100 granted, then svc_sel = 4'b0110: grant remains 4'b0100.
- Finish lock: owner service2 pulses svc_finish[2].
  - State goes to LOCK, grant = 0.
  - Grant does not return while svc_sel[2] stays 1.
  - Drop and re-raise svc_sel[2]: re-grant after the blank gap.
- Alarm pre-emption: service1 owns, alarm_ring rises.
  - Within 1 cycle grant = 0; BLANK; then grant = 4'b0001.
  - Toggling svc_sel has no effect.
  - svc_finish[0] returns to IDLE; alarm_ring still high does not re-grant.
- Mid-operation reset: pulse resetn = 1 during BLANK and again during OWN.
  - Next cycle grant = 0, disp_num = FFFF, disp_an = 0, svc_push = 0, sel_err = 0.

Source files
------------

// File: rtl/service_arbiter_pkg.sv
// rtl/service_arbiter_pkg.sv - shared types and constants for the service arbiter
// Purpose: FSM state encoding, service one-hot codes, blank digit pattern,
//          push-button bit indices and a one-hot helper.
// Ports:   none (package).
package service_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_OWN   = 2'd2,
    ST_LOCK  = 2'd3
  } state_e;

  localparam logic [3:0] SVC1 = 4'b1000;
  localparam logic [3:0] SVC2 = 4'b0100;
  localparam logic [3:0] SVC3 = 4'b0010;
  localparam logic [3:0] SVC4 = 4'b0001;

  localparam logic [15:0] BLANK_DIGITS = 16'hFFFF;

  localparam int U = 0;
  localparam int D = 1;
  localparam int L = 2;
  localparam int R = 3;
  localparam int M = 4;

  localparam int PUSH_W  = 5;
  localparam int DIGIT_W = 16;
  localparam int AN_W    = 4;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/service_push_gate.sv
// rtl/service_push_gate.sv - per-owner button gating with release re-arm
// Purpose: forwards the raw buttons to the owning service's slice, one cycle
//          late, but only after the buttons have been seen fully released
//          since ownership began.
// Ports:   clk_i, rst_i (sync, active-high), grant_i (one-hot owner, 0 = none),
//          hold_i (ownership continues next cycle), push_i (raw {m,r,l,d,u}),
//          svc_push_o (gated buttons, highest slice = service1).
module service_push_gate
  import service_arbiter_pkg::*;
#(
  parameter int N_SVC = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_SVC-1:0]          grant_i,
  input  logic                      hold_i,
  input  logic [PUSH_W-1:0]         push_i,
  output logic [PUSH_W*N_SVC-1:0]   svc_push_o
);

  logic                    armed_q, armed_d;
  logic [PUSH_W*N_SVC-1:0] svc_push_q, svc_push_d;

  always_comb begin
    armed_d = armed_q;
    // Any gap in ownership forgets the release, so a press held across a
    // switchover never reaches the new owner.
    if (grant_i == '0) begin
      armed_d = 1'b0;
    end else if (push_i == '0) begin
      armed_d = 1'b1;
    end
  end

  always_comb begin
    svc_push_d = '0;
    for (int i = 0; i < N_SVC; i++) begin
      if (hold_i && armed_q && grant_i[i]) begin
        svc_push_d[PUSH_W*i +: PUSH_W] = push_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed_q    <= 1'b0;
      svc_push_q <= '0;
    end else begin
      armed_q    <= armed_d;
      svc_push_q <= svc_push_d;
    end
  end

  assign svc_push_o = svc_push_q;

endmodule

// File: rtl/service_arbiter.sv
// rtl/service_arbiter.sv - display/button ownership arbiter for four services
// Purpose: grants the 7-segment bus and buttons to one service at a time,
//          blanks the display on every switchover, locks out a finished
//          service until its switch drops, and lets the alarm pre-empt.
// Ports:   clk_i, resetn_i (sync, active-high: 1 = reset), svc_sel_i,
//          push_i, svc_num_i, svc_an_i, svc_finish_i, alarm_ring_i;
//          grant_o, svc_push_o, disp_num_o, disp_an_o, sel_err_o (all registered).
module service_arbiter
  import service_arbiter_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter int N_SVC        = 4
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic [N_SVC-1:0]          svc_sel_i,
  input  logic [PUSH_W-1:0]         push_i,
  input  logic [DIGIT_W*N_SVC-1:0]  svc_num_i,
  input  logic [AN_W*N_SVC-1:0]     svc_an_i,
  input  logic [N_SVC-1:0]          svc_finish_i,
  input  logic                      alarm_ring_i,
  output logic [N_SVC-1:0]          grant_o,
  output logic [PUSH_W*N_SVC-1:0]   svc_push_o,
  output logic [DIGIT_W-1:0]        disp_num_o,
  output logic [AN_W-1:0]           disp_an_o,
  output logic                      sel_err_o
);

  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(BLANK_CYCLES - 1);

  state_e              state_q, state_d;
  logic [N_SVC-1:0]    target_q, target_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                alarm_pre_q, alarm_pre_d;
  logic                alarm_hold_q, alarm_hold_d;
  logic [N_SVC-1:0]    grant_q, grant_d;
  logic [DIGIT_W-1:0]  disp_num_q, disp_num_d;
  logic [AN_W-1:0]     disp_an_q, disp_an_d;
  logic                sel_err_q, sel_err_d;

  logic                owner_sel, owner_fin, alarm_trig;
  logic [DIGIT_W-1:0]  mux_num;
  logic [AN_W-1:0]     mux_an;

  assign owner_sel = |(svc_sel_i & target_q);
  assign owner_fin = |(svc_finish_i & target_q);
  // alarm_hold_q blocks re-triggering until the ring level has been low once.
  assign alarm_trig = alarm_ring_i && !alarm_hold_q &&
                      (state_q != ST_BLANK) && (grant_q != SVC4);

  always_comb begin
    mux_num = BLANK_DIGITS;
    mux_an  = '0;
    for (int i = 0; i < N_SVC; i++) begin
      if (grant_q[i]) begin
        mux_num = svc_num_i[DIGIT_W*i +: DIGIT_W];
        mux_an  = svc_an_i[AN_W*i +: AN_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    alarm_pre_d  = alarm_pre_q;
    alarm_hold_d = alarm_hold_q & alarm_ring_i;
    sel_err_d    = 1'b0;

    if (alarm_trig) begin
      state_d      = ST_BLANK;
      target_d     = SVC4;
      cnt_d        = CNT_INIT;
      alarm_pre_d  = 1'b1;
      alarm_hold_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (is_onehot(svc_sel_i)) begin
            state_d  = ST_BLANK;
            target_d = svc_sel_i;
            cnt_d    = CNT_INIT;
          end else begin
            sel_err_d = |svc_sel_i;
          end
        end
        ST_BLANK: begin
          if (cnt_q == '0) begin
            state_d = ST_OWN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_OWN: begin
          if (alarm_pre_q) begin
            // Alarm service ignores switches; only its own finish ends it.
            if (owner_fin) begin
              state_d     = ST_IDLE;
              alarm_pre_d = 1'b0;
            end
          end else if (owner_fin) begin
            state_d = ST_LOCK;
          end else if (!owner_sel) begin
            state_d = ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (!owner_sel) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    grant_d = (state_d == ST_OWN) ? target_d : '0;
    // The owner's digits appear one cycle after its grant and vanish with it.
    if ((state_q == ST_OWN) && (state_d == ST_OWN)) begin
      disp_num_d = mux_num;
      disp_an_d  = mux_an;
    end else begin
      disp_num_d = BLANK_DIGITS;
      disp_an_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (resetn_i) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      cnt_q        <= '0;
      alarm_pre_q  <= 1'b0;
      alarm_hold_q <= 1'b0;
      grant_q      <= '0;
      disp_num_q   <= BLANK_DIGITS;
      disp_an_q    <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      alarm_pre_q  <= alarm_pre_d;
      alarm_hold_q <= alarm_hold_d;
      grant_q      <= grant_d;
      disp_num_q   <= disp_num_d;
      disp_an_q    <= disp_an_d;
      sel_err_q    <= sel_err_d;
    end
  end

  service_push_gate #(.N_SVC(N_SVC)) u_push_gate (
    .clk_i      (clk_i),
    .rst_i      (resetn_i),
    .grant_i    (grant_q),
    .hold_i     (state_d == ST_OWN),
    .push_i     (push_i),
    .svc_push_o (svc_push_o)
  );

  assign grant_o    = grant_q;
  assign disp_num_o = disp_num_q;
  assign disp_an_o  = disp_an_q;
  assign sel_err_o  = sel_err_q;

endmodule
